// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package sevenseg_pkg;

  typedef logic [3:0] bcd_t;

  // Code the downstream decoder renders as all segments off.
  localparam bcd_t BLANK_CODE = 4'hF;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_if.sv
// Value/control inputs and display outputs of the scan controller.
interface sevenseg_if
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      blank_lz;
  bcd_t                      digit;
  logic [NUM_DIGITS-1:0]     anode_n;
  logic                      pending;
  logic                      frame_start;

  modport master (
    output load, value, blank_lz,
    input  digit, anode_n, pending, frame_start
  );

  modport slave (
    input  load, value, blank_lz,
    output digit, anode_n, pending, frame_start
  );

endinterface

// File: rtl/sevenseg_lz_mask.sv
// Leading-zero blank mask: marks zero digits above the most significant nonzero one.
module sevenseg_lz_mask
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] active_i,
  input  logic                    en_i,
  output logic [NUM_DIGITS-1:0]   mask_o
);

  logic seen_nz;

  // Walk from the top digit down; digit 0 is never blanked.
  always_comb begin
    mask_o  = '0;
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (en_i && !seen_nz && (bcd_t'(active_i[4*i +: 4]) == bcd_t'(0))) begin
        mask_o[i] = 1'b1;
      end else begin
        seen_nz = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// frame-synchronous double-buffered value updates and optional leading-zero blanking.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  sevenseg_if.slave bus
);

  localparam int unsigned PW = cnt_width(REFRESH_DIV);
  localparam int unsigned IW = cnt_width(NUM_DIGITS);
  localparam int unsigned VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PrescLast = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BlankLen  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IdxLast   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [VW-1:0]         active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  frame_start_q, frame_start_d;
  bcd_t                  digit_q, digit_d;
  logic [NUM_DIGITS-1:0] anode_n_q, anode_n_d;

  logic                  slot_wrap;
  logic                  frame_end;
  logic                  in_blank;
  logic [NUM_DIGITS-1:0] lz_mask;
  bcd_t                  act_dig [NUM_DIGITS];

  // Mask is taken on the next active value so outputs track the same edge.
  sevenseg_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .active_i (active_d),
    .en_i     (bus.blank_lz),
    .mask_o   (lz_mask)
  );

  // Prescaler, digit index and double-buffer transfer.
  always_comb begin
    slot_wrap = (presc_q == PrescLast);
    frame_end = slot_wrap && (idx_q == IdxLast);
    presc_d   = slot_wrap ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end

    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frame_end) begin
      // A load landing on the boundary bypasses the shadow wait.
      if (bus.load) begin
        shadow_d  = bus.value;
        active_d  = bus.value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (bus.load) begin
      shadow_d  = bus.value;
      pending_d = 1'b1;
    end

    frame_start_d = frame_end;
  end

  // Split the next active value into per-digit codes.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      act_dig[i] = bcd_t'(active_d[4*i +: 4]);
    end
  end

  // Next output values from the post-edge slot position.
  always_comb begin
    in_blank  = (presc_d < BlankLen);
    anode_n_d = '1;
    digit_d   = BLANK_CODE;
    if (!in_blank) begin
      anode_n_d[idx_d] = 1'b0;
      digit_d          = lz_mask[idx_d] ? BLANK_CODE : act_dig[idx_d];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      digit_q       <= BLANK_CODE;
      anode_n_q     <= '1;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      digit_q       <= digit_d;
      anode_n_q     <= anode_n_d;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.anode_n     = anode_n_q;
  assign bus.pending     = pending_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan against a slot/frame-arithmetic reference model.
module tb_sevenseg_scan;
  import sevenseg_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned DIV   = 16;
  localparam int unsigned BLK   = 2;
  localparam int unsigned FRAME = N * DIV;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  sevenseg_if #(.NUM_DIGITS(N)) bus ();

  sevenseg_scan #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: edges since reset release, displayed value, buffered value.
  int unsigned m_t;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pending;
  bit          m_blz;

  logic [9:0] obs;
  logic [9:0] exp;

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'd0: return 7'b111_1110;
      4'd1: return 7'b011_0000;
      4'd2: return 7'b110_1101;
      4'd3: return 7'b111_1001;
      4'd4: return 7'b011_0011;
      4'd5: return 7'b101_1011;
      4'd6: return 7'b101_1111;
      4'd7: return 7'b111_0000;
      4'd8: return 7'b111_1111;
      4'd9: return 7'b111_1011;
      default: return 7'b000_0000;
    endcase
  endfunction

  // Expected {anode_n, digit, pending, frame_start} from slot arithmetic.
  function automatic logic [9:0] exp_vec();
    int unsigned presc = m_t % DIV;
    int unsigned idx   = (m_t / DIV) % N;
    int          top   = -1;
    logic [3:0]  an    = 4'hF;
    logic [3:0]  d     = 4'hF;
    logic        fs    = (m_t != 0) && (m_t % FRAME == 0);
    if (presc >= BLK) begin
      an = ~(4'b0001 << idx);
      for (int i = 0; i < N; i++) begin
        if (((m_active >> (4 * i)) & 16'hF) != 16'h0) top = i;
      end
      d = 4'((m_active >> (4 * idx)) & 16'hF);
      if (m_blz && idx > 0 && int'(idx) > top) d = 4'hF;
    end
    return {an, d, m_pending, fs};
  endfunction

  task automatic model_reset();
    m_t = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_blz = 1'b0;
  endtask

  task automatic drive(input bit ld, input logic [15:0] v, input bit blz);
    bus.load = ld; bus.value = v; bus.blank_lz = blz;
  endtask

  // Advance model by one edge using inputs present before it, then clock the DUT.
  task automatic tick();
    bit          ld = bus.load;
    logic [15:0] v  = bus.value;
    m_blz = bus.blank_lz;
    m_t++;
    if (m_t % FRAME == 0) begin
      if (ld) begin
        m_active = v; m_shadow = v; m_pending = 1'b0;
      end else if (m_pending) begin
        m_active = m_shadow; m_pending = 1'b0;
      end
    end else if (ld) begin
      m_shadow = v; m_pending = 1'b1;
    end
    @(posedge clk);
    #1;
    obs = {bus.anode_n, bus.digit, bus.pending, bus.frame_start};
    exp = exp_vec();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    model_reset();
    #12;
    obs = {bus.anode_n, bus.digit, bus.pending, bus.frame_start};
    checks++;
    if (obs !== {4'hF, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", obs, {4'hF, 4'hF, 1'b0, 1'b0});
    end
    @(negedge clk);
    reset_n = 1'b1;
    obs = {bus.anode_n, bus.digit, bus.pending, bus.frame_start};
    exp = exp_vec();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", obs, exp);
    end
  endtask

  task automatic test_scan();
    for (int c = 0; c < 130; c++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL scan t=%0d: got %b expected %b", m_t, obs, exp);
      end
      if (m_t == 1 || m_t == 16) begin
        checks++;
        if (bus.anode_n !== 4'b1111 || bus.digit !== 4'hF) begin
          errors++;
          $display("FAIL scan_blank t=%0d: got %b/%h expected 1111/f", m_t, bus.anode_n, bus.digit);
        end
      end
      if (m_t == 2 || m_t == 18) begin
        checks++;
        if (bus.anode_n !== ((m_t == 2) ? 4'b1110 : 4'b1101) || bus.digit !== 4'h0) begin
          errors++;
          $display("FAIL scan_anode t=%0d: got %b/%h", m_t, bus.anode_n, bus.digit);
        end
      end
      if (m_t == 64 || m_t == 128) begin
        checks++;
        if (bus.frame_start !== 1'b1) begin
          errors++;
          $display("FAIL scan_frame_start t=%0d: got %b expected 1", m_t, bus.frame_start);
        end
      end
    end
  endtask

  task automatic test_double_buffer();
    while (m_t % FRAME != 20) tick();
    drive(1'b1, 16'h1234, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    checks++;
    if (bus.pending !== 1'b1 || bus.digit !== 4'h0) begin
      errors++;
      $display("FAIL dbuf_pending: got pending=%b digit=%h expected 1/0", bus.pending, bus.digit);
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL dbuf t=%0d: got %b expected %b", m_t, obs, exp);
      end
      if (m_t % FRAME == 0) begin
        checks++;
        if (bus.pending !== 1'b0) begin
          errors++;
          $display("FAIL dbuf_clear t=%0d: got pending=%b expected 0", m_t, bus.pending);
        end
      end
      if (m_t % FRAME == 5 && m_t > 64) begin
        checks++;
        if (bus.digit !== 4'h4 || seg7(bus.digit) !== 7'b011_0011 || bus.anode_n !== 4'b1110) begin
          errors++;
          $display("FAIL dbuf_digit0: got %h/%b expected 4/1110", bus.digit, bus.anode_n);
        end
      end
    end
  endtask

  task automatic test_last_wins();
    while (m_t % FRAME != 10) tick();
    drive(1'b1, 16'h1111, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    drive(1'b1, 16'h5678, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    while (m_t % FRAME != 63) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL last_wins t=%0d: got %b expected %b", m_t, obs, exp);
      end
      if (m_t % FRAME == 20 && m_pending == 1'b0) begin
        checks++;
        if (bus.digit !== 4'h7) begin
          errors++;
          $display("FAIL last_wins_digit1: got %h expected 7", bus.digit);
        end
      end
    end
    drive(1'b1, 16'h9999, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    checks++;
    if (bus.pending !== 1'b0 || bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL coincident: got pending=%b fs=%b expected 0/1", bus.pending, bus.frame_start);
    end
    for (int c = 0; c < FRAME; c++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL coincident t=%0d: got %b expected %b", m_t, obs, exp);
      end
      if (m_t % FRAME == 53) begin
        checks++;
        if (bus.digit !== 4'h9 || bus.anode_n !== 4'b0111) begin
          errors++;
          $display("FAIL coincident_digit3: got %h/%b expected 9/0111", bus.digit, bus.anode_n);
        end
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [3] = '{16'h0040, 16'h0000, 16'h0000};
    bit          blzs [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, vals[k], blzs[k]);
      tick();
      drive(1'b0, 16'h0, blzs[k]);
      for (int c = 0; c < 2 * FRAME; c++) begin
        tick();
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL lz%0d t=%0d: got %b expected %b", k, m_t, obs, exp);
        end
        if (!m_pending && m_t % FRAME == 53) begin
          checks++;
          if (bus.digit !== (blzs[k] ? 4'hF : 4'h0) || bus.anode_n !== 4'b0111) begin
            errors++;
            $display("FAIL lz%0d_digit3: got %h/%b", k, bus.digit, bus.anode_n);
          end
        end
        if (!m_pending && m_t % FRAME == 5) begin
          checks++;
          if (seg7(bus.digit) !== 7'b111_1110) begin
            errors++;
            $display("FAIL lz%0d_digit0: got seg %b expected 1111110", k, seg7(bus.digit));
          end
        end
      end
    end
  endtask

  task automatic test_invalid();
    drive(1'b1, 16'h00A0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL invalid t=%0d: got %b expected %b", m_t, obs, exp);
      end
      if (!m_pending && m_t % FRAME == 21) begin
        checks++;
        if (bus.digit !== 4'hA || seg7(bus.digit) !== 7'b0 || bus.anode_n !== 4'b1101) begin
          errors++;
          $display("FAIL invalid_digit1: got %h/%b expected a/1101", bus.digit, bus.anode_n);
        end
      end
    end
  endtask

  task automatic test_random();
    bit blz = 1'b0;
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(15) == 0) blz = ~blz;
      drive($urandom_range(7) == 0, 16'($urandom), blz);
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random t=%0d: got %b expected %b", m_t, obs, exp);
      end
    end
    drive(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_async_reset();
    while (m_t % FRAME != 5) tick();
    drive(1'b1, 16'h4321, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    while (m_t % FRAME != 2 * DIV + 7) tick();
    checks++;
    if (bus.pending !== 1'b1 || bus.anode_n !== 4'b1011) begin
      errors++;
      $display("FAIL pre_reset: got pending=%b anode=%b expected 1/1011", bus.pending, bus.anode_n);
    end
    #2 reset_n = 1'b0;
    #1;
    obs = {bus.anode_n, bus.digit, bus.pending, bus.frame_start};
    checks++;
    if (obs !== {4'hF, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", obs, {4'hF, 4'hF, 1'b0, 1'b0});
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL post_reset t=%0d: got %b expected %b", m_t, obs, exp);
      end
      if (m_t == 2) begin
        checks++;
        if (bus.anode_n !== 4'b1110 || bus.digit !== 4'h0) begin
          errors++;
          $display("FAIL restart_idx0: got %b/%h expected 1110/0", bus.anode_n, bus.digit);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_double_buffer();
    test_last_wins();
    test_lz();
    test_invalid();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
